// File: rtl/id_ex_stage.sv
// ID/EX register with load-use stall and halt latch; id_* appear on ID_EX_* one cycle after capture.
// Backpressure: pc_write/IF_ID_write drop combinationally on a load-use hazard or once halted.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] IF_ID_Rs,
    input  logic [REG_AW-1:0] IF_ID_Rt,
    input  logic [REG_AW-1:0] IF_ID_Rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_halt,
    input  logic [3:0]        id_AluOp,
    input  logic              flush,
    output logic [REG_AW-1:0] ID_EX_Rs,
    output logic [REG_AW-1:0] ID_EX_Rt,
    output logic [REG_AW-1:0] ID_EX_Rd,
    output logic [DATA_W-1:0] ID_EX_rs_data,
    output logic [DATA_W-1:0] ID_EX_rt_data,
    output logic [DATA_W-1:0] ID_EX_imm,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_halt,
    output logic              ID_EX_valid,
    output logic [3:0]        ID_EX_AluOp,
    output logic              pc_write,
    output logic              IF_ID_write,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

    state_t            r_state;
    logic [REG_AW-1:0] r_rs, r_rt, r_rd;
    logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm;
    logic              r_regwrite, r_memread, r_memwrite, r_halt, r_valid;
    logic [3:0]        r_aluop;
    logic [CNT_W-1:0]  r_stall_count;

    logic w_run, w_lu, w_capture, w_count;

    // Register 0 is hardwired, so a load to it can never create a dependency.
    assign w_run     = (r_state == ST_RUN);
    assign w_lu      = r_valid & r_memread & (r_rd != '0) &
                       ((r_rd == IF_ID_Rs) | (id_uses_rt & (r_rd == IF_ID_Rt)));
    assign w_capture = w_run & ~flush & ~w_lu;
    assign w_count   = w_run & ~flush & w_lu & (r_stall_count != '1);

    assign pc_write    = w_run & (flush | ~w_lu);
    assign IF_ID_write = w_run & (flush | ~w_lu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_regwrite    <= 1'b0;
            r_memread     <= 1'b0;
            r_memwrite    <= 1'b0;
            r_halt        <= 1'b0;
            r_valid       <= 1'b0;
            r_aluop       <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_capture) begin
                r_rs       <= IF_ID_Rs;
                r_rt       <= IF_ID_Rt;
                r_rd       <= IF_ID_Rd;
                r_rs_data  <= id_rs_data;
                r_rt_data  <= id_rt_data;
                r_imm      <= id_imm;
                r_regwrite <= id_RegWrite;
                r_memread  <= id_MemRead;
                r_memwrite <= id_MemWrite;
                r_halt     <= id_halt;
                r_valid    <= 1'b1;
                r_aluop    <= id_AluOp;
                if (id_halt) begin
                    r_state <= ST_HALTED;
                end
            end else begin
                // Bubble: all-zero addresses keep the forwarding unit from matching.
                r_rs       <= '0;
                r_rt       <= '0;
                r_rd       <= '0;
                r_rs_data  <= '0;
                r_rt_data  <= '0;
                r_imm      <= '0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_halt     <= 1'b0;
                r_valid    <= 1'b0;
                r_aluop    <= '0;
            end
            if (w_count) begin
                r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign ID_EX_Rs       = r_rs;
    assign ID_EX_Rt       = r_rt;
    assign ID_EX_Rd       = r_rd;
    assign ID_EX_rs_data  = r_rs_data;
    assign ID_EX_rt_data  = r_rt_data;
    assign ID_EX_imm      = r_imm;
    assign ID_EX_RegWrite = r_regwrite;
    assign ID_EX_MemRead  = r_memread;
    assign ID_EX_MemWrite = r_memwrite;
    assign ID_EX_halt     = r_halt;
    assign ID_EX_valid    = r_valid;
    assign ID_EX_AluOp    = r_aluop;
    assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a transaction-level model.
module tb_id_ex_stage;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] if_rs = '0, if_rt = '0, if_rd = '0;
    logic          uses_rt = 1'b0;
    logic [DW-1:0] rs_d = '0, rt_d = '0, imm = '0;
    logic          rw = 1'b0, mr = 1'b0, mw = 1'b0, hlt = 1'b0, flush = 1'b0;
    logic [3:0]    op = '0;

    logic [AW-1:0] o_rs, o_rt, o_rd;
    logic [DW-1:0] o_rs_d, o_rt_d, o_imm;
    logic          o_rw, o_mr, o_mw, o_halt, o_valid, o_pcw, o_ifw;
    logic [3:0]    o_op;
    logic [CW-1:0] o_cnt;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(if_rs), .IF_ID_Rt(if_rt), .IF_ID_Rd(if_rd), .id_uses_rt(uses_rt),
        .id_rs_data(rs_d), .id_rt_data(rt_d), .id_imm(imm),
        .id_RegWrite(rw), .id_MemRead(mr), .id_MemWrite(mw), .id_halt(hlt),
        .id_AluOp(op), .flush(flush),
        .ID_EX_Rs(o_rs), .ID_EX_Rt(o_rt), .ID_EX_Rd(o_rd),
        .ID_EX_rs_data(o_rs_d), .ID_EX_rt_data(o_rt_d), .ID_EX_imm(o_imm),
        .ID_EX_RegWrite(o_rw), .ID_EX_MemRead(o_mr), .ID_EX_MemWrite(o_mw),
        .ID_EX_halt(o_halt), .ID_EX_valid(o_valid), .ID_EX_AluOp(o_op),
        .pc_write(o_pcw), .IF_ID_write(o_ifw), .stall_count(o_cnt)
    );

    always #5 clk = ~clk;

    // Model: what EX currently holds, whether the core has halted, and stalls seen.
    typedef struct {
        bit        valid;
        bit [3:0]  rs, rt, rd;
        bit [15:0] a, b, imm;
        bit        rw, mr, mw, halt;
        bit [3:0]  op;
    } ex_t;

    ex_t m_ex, m_next, bubble;
    bit  m_halted, m_halted_next;
    int  m_cnt, m_cnt_next;
    int  n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid",    32'(o_valid), 32'(m_ex.valid));
        chk("Rs",       32'(o_rs),    32'(m_ex.rs));
        chk("Rt",       32'(o_rt),    32'(m_ex.rt));
        chk("Rd",       32'(o_rd),    32'(m_ex.rd));
        chk("rs_data",  32'(o_rs_d),  32'(m_ex.a));
        chk("rt_data",  32'(o_rt_d),  32'(m_ex.b));
        chk("imm",      32'(o_imm),   32'(m_ex.imm));
        chk("RegWrite", 32'(o_rw),    32'(m_ex.rw));
        chk("MemRead",  32'(o_mr),    32'(m_ex.mr));
        chk("MemWrite", 32'(o_mw),    32'(m_ex.mw));
        chk("halt",     32'(o_halt),  32'(m_ex.halt));
        chk("AluOp",    32'(o_op),    32'(m_ex.op));
        chk("stall_count", 32'(o_cnt), 32'(m_cnt));
    endtask

    // Called with inputs settled before the edge: checks the front-end enables and
    // works out what the coming edge must do.
    task automatic eval();
        bit hz, exp_pcw;
        #1;
        hz = m_ex.valid && m_ex.mr && m_ex.rd != 0 &&
             (m_ex.rd == if_rs || (uses_rt && m_ex.rd == if_rt));
        exp_pcw = !m_halted && (flush || !hz);
        chk("pc_write",    32'(o_pcw), 32'(exp_pcw));
        chk("IF_ID_write", 32'(o_ifw), 32'(exp_pcw));
        if (m_halted || flush || hz) begin
            m_next = bubble;
        end else begin
            m_next = '{1'b1, if_rs, if_rt, if_rd, rs_d, rt_d, imm, rw, mr, mw, hlt, op};
        end
        m_halted_next = m_halted || (!flush && !hz && hlt);
        m_cnt_next    = (!m_halted && !flush && hz && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    endtask

    task automatic tick();
        @(posedge clk);
        m_ex     = m_next;
        m_halted = m_halted_next;
        m_cnt    = m_cnt_next;
        #1;
        check_all();
    endtask

    task automatic model_reset();
        m_ex = bubble; m_halted = 0; m_cnt = 0;
    endtask

    // Asserts reset wherever the bench currently is and checks the immediate effect.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("pc_write_rst", 32'(o_pcw), 32'd1);
        chk("IF_ID_write_rst", 32'(o_ifw), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_instr(input bit [3:0] s, input bit [3:0] t, input bit [3:0] d,
                             input bit ut, input bit load, input bit wr, input bit h,
                             input bit fl);
        if_rs = s; if_rt = t; if_rd = d; uses_rt = ut;
        mr = load; rw = wr | load; mw = 1'b0; hlt = h; flush = fl;
        rs_d = 16'($urandom); rt_d = 16'($urandom); imm = 16'($urandom);
        op = 4'($urandom);
    endtask

    task automatic step(input bit [3:0] s, input bit [3:0] t, input bit [3:0] d,
                        input bit ut, input bit load, input bit wr, input bit h, input bit fl);
        set_instr(s, t, d, ut, load, wr, h, fl);
        eval();
        tick();
    endtask

    initial begin
        bubble = '{1'b0, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        model_reset();
        do_reset();
        chk("rst_valid_lit", 32'(o_valid), 32'd0);
        chk("rst_cnt_lit",   32'(o_cnt),   32'd0);

        // Load-use on Rs
        step(4'd1, 4'd2, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_instr(4'd5, 4'd6, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        eval();
        chk("lu_rs_pcw_lit", 32'(o_pcw), 32'd0);
        chk("lu_rs_ifw_lit", 32'(o_ifw), 32'd0);
        tick();
        chk("lu_rs_bubble_lit", 32'(o_valid), 32'd0);
        chk("lu_rs_cnt_lit", 32'(o_cnt), 32'd1);
        eval();
        chk("lu_rs_resume_pcw_lit", 32'(o_pcw), 32'd1);
        tick();
        chk("lu_rs_capture_lit", 32'(o_rs), 32'd5);
        chk("lu_rs_valid_lit", 32'(o_valid), 32'd1);

        // Rt gating by id_uses_rt
        step(4'd1, 4'd1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_instr(4'd1, 4'd3, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        eval();
        chk("rt_unused_pcw_lit", 32'(o_pcw), 32'd1);
        tick();
        step(4'd1, 4'd1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_instr(4'd1, 4'd3, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        eval();
        chk("rt_used_pcw_lit", 32'(o_pcw), 32'd0);
        tick();
        chk("rt_used_cnt_lit", 32'(o_cnt), 32'd2);
        tick_again: begin eval(); tick(); end

        // R0 load and ALU producer never stall
        step(4'd1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_instr(4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        eval();
        chk("r0_pcw_lit", 32'(o_pcw), 32'd1);
        tick();
        step(4'd1, 4'd1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_instr(4'd5, 4'd5, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        eval();
        chk("alu_pcw_lit", 32'(o_pcw), 32'd1);
        tick();

        // Flush beats load-use
        step(4'd1, 4'd1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_instr(4'd5, 4'd5, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        eval();
        chk("flush_pcw_lit", 32'(o_pcw), 32'd1);
        tick();
        chk("flush_bubble_lit", 32'(o_valid), 32'd0);
        chk("flush_cnt_lit", 32'(o_cnt), 32'd2);

        // Halt, then flush pulses, then reset
        step(4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("halt_lit", 32'(o_halt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_instr(4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, i[0]);
            eval();
            chk("halted_pcw_lit", 32'(o_pcw), 32'd0);
            tick();
            chk("halted_halt_lit", 32'(o_halt), 32'd0);
        end
        flush = 1'b0;
        do_reset();

        // Reset in the middle of a stall
        step(4'd1, 4'd1, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_instr(4'd6, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        eval();
        chk("midstall_pcw_lit", 32'(o_pcw), 32'd0);
        do_reset();
        chk("midstall_rst_cnt_lit", 32'(o_cnt), 32'd0);

        // Saturation
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            step(4'd0, 4'd0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            step(4'd5, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_cnt_lit", 32'(o_cnt), 32'(CNT_MAX));
        do_reset();

        // Random traffic biased toward register collisions
        for (int i = 0; i < 3000; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                set_instr(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                          4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                          1'($urandom), ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 7) == 0));
                mw = 1'($urandom);
                eval();
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
